// File: rtl/pipe_adder_if.sv
// Operand and result streams of pipe_adder, each a valid/ready handshake.
// The producer of operands and consumer of results takes the master side.
interface pipe_adder_if #(
    parameter int WIDTH = 32
);
    logic             io_in_valid;
    logic             io_in_ready;
    logic             io_in_cin;
    logic             io_in_sub;
    logic [WIDTH-1:0] io_in_lhs;
    logic [WIDTH-1:0] io_in_rhs;
    logic             io_out_valid;
    logic             io_out_ready;
    logic [WIDTH-1:0] io_out_sum;
    logic             io_out_cout;
    logic             io_out_ovf;

    modport master (
        output io_in_valid, io_in_cin, io_in_sub, io_in_lhs, io_in_rhs, io_out_ready,
        input  io_in_ready, io_out_valid, io_out_sum, io_out_cout, io_out_ovf
    );

    modport slave (
        input  io_in_valid, io_in_cin, io_in_sub, io_in_lhs, io_in_rhs, io_out_ready,
        output io_in_ready, io_out_valid, io_out_sum, io_out_cout, io_out_ovf
    );
endinterface

// File: rtl/pipe_adder.sv
// Pipelined add/subtract: WIDTH bits summed CHUNK bits per stage, with the carry
// registered at each stage boundary. Streams at one beat per cycle with backpressure.
module pipe_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic        clk,
    input  logic        reset,
    pipe_adder_if.slave bus
);
    localparam int CHUNK = WIDTH / STAGES;

    logic [WIDTH-1:0] b_in_s;
    logic             c0_s;
    logic             in_ready_s;

    // Subtract is lhs + ~rhs + ~borrow, so the pipeline itself only ever adds.
    assign b_in_s = bus.io_in_sub ? ~bus.io_in_rhs : bus.io_in_rhs;
    assign c0_s   = bus.io_in_sub ? ~bus.io_in_cin : bus.io_in_cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int SRC_W = WIDTH - k * CHUNK;
        localparam int SUM_W = (k + 1) * CHUNK;

        logic             valid_q;
        logic             adv_s;
        logic             load_s;
        logic             cin_s;
        logic [SRC_W-1:0] lhs_src_s;
        logic [SRC_W-1:0] b_src_s;
        logic [CHUNK:0]   chunk_s;
        logic [SUM_W-1:0] sum_d;
        logic [SUM_W-1:0] sum_q;
        logic             carry_q;

        assign chunk_s = {1'b0, lhs_src_s[CHUNK-1:0]} + {1'b0, b_src_s[CHUNK-1:0]}
                       + {{CHUNK{1'b0}}, cin_s};

        if (k == 0) begin : g_src
            assign load_s    = bus.io_in_valid && in_ready_s;
            assign lhs_src_s = bus.io_in_lhs;
            assign b_src_s   = b_in_s;
            assign cin_s     = c0_s;
            assign sum_d     = chunk_s[CHUNK-1:0];
        end else begin : g_src
            assign load_s    = g_stage[k-1].valid_q && g_stage[k-1].adv_s;
            assign lhs_src_s = g_stage[k-1].g_hi.lhs_hi_q;
            assign b_src_s   = g_stage[k-1].g_hi.b_hi_q;
            assign cin_s     = g_stage[k-1].carry_q;
            assign sum_d     = {chunk_s[CHUNK-1:0], g_stage[k-1].sum_q};
        end

        // Stage register: hold while stalled, otherwise take what upstream offers.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                valid_q <= 1'b0;
                sum_q   <= {SUM_W{1'b0}};
                carry_q <= 1'b0;
            end else if (adv_s) begin
                valid_q <= load_s;
                if (load_s) begin
                    sum_q   <= sum_d;
                    carry_q <= chunk_s[CHUNK];
                end
            end
        end

        if (k < STAGES - 1) begin : g_hi
            logic [SRC_W-CHUNK-1:0] lhs_hi_q;
            logic [SRC_W-CHUNK-1:0] b_hi_q;

            // An empty downstream stage never blocks, so bubbles collapse under stall.
            assign adv_s = !valid_q || g_stage[k+1].adv_s || !g_stage[k+1].valid_q;

            // Unsummed upper operand chunks travel with the beat; their MSB is the sign.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    lhs_hi_q <= {(SRC_W-CHUNK){1'b0}};
                    b_hi_q   <= {(SRC_W-CHUNK){1'b0}};
                end else if (adv_s && load_s) begin
                    lhs_hi_q <= lhs_src_s[SRC_W-1:CHUNK];
                    b_hi_q   <= b_src_s[SRC_W-1:CHUNK];
                end
            end
        end else begin : g_last
            logic ovf_d;
            logic ovf_q;

            assign adv_s = !valid_q || bus.io_out_ready;
            assign ovf_d = (lhs_src_s[SRC_W-1] == b_src_s[SRC_W-1])
                        && (chunk_s[CHUNK-1] != lhs_src_s[SRC_W-1]);

            // Overflow is resolved here, where the top chunk and both signs meet.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    ovf_q <= 1'b0;
                end else if (adv_s && load_s) begin
                    ovf_q <= ovf_d;
                end
            end
        end
    end

    assign in_ready_s       = !g_stage[0].valid_q || g_stage[0].adv_s;
    assign bus.io_in_ready  = in_ready_s;
    assign bus.io_out_valid = g_stage[STAGES-1].valid_q;
    assign bus.io_out_sum   = g_stage[STAGES-1].sum_q;
    assign bus.io_out_cout  = g_stage[STAGES-1].carry_q;
    assign bus.io_out_ovf   = g_stage[STAGES-1].g_last.ovf_q;
endmodule

// File: tb/tb_pipe_adder.sv
// Scoreboard bench for pipe_adder: an 8-bit/2-stage instance for directed cases and
// a 32-bit/4-stage instance for randomized valid/ready streaming.
module tb_pipe_adder;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipe_adder_if #(.WIDTH(8))  bus8();
    pipe_adder_if #(.WIDTH(32)) bus32();

    pipe_adder #(.WIDTH(8), .STAGES(2)) dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus8.slave)
    );

    pipe_adder #(.WIDTH(32), .STAGES(4)) dut32 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus32.slave)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [33:0] q8[$];
    logic [33:0] q32[$];
    logic [33:0] exp8_next;
    logic [33:0] e8;
    logic [33:0] e32;
    logic        rnd8_en = 1'b0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Golden model: plain wide arithmetic, returns {ovf, cout, sum[31:0]}.
    function automatic logic [33:0] model(input int w, input logic [31:0] l, input logic [31:0] r,
                                          input logic cin, input logic sub);
        logic [63:0] mask;
        logic [63:0] b;
        logic [63:0] full;
        logic [31:0] s;
        logic        c0;
        logic        co;
        logic        ov;
        mask = (64'd1 << w) - 64'd1;
        b    = (sub ? ~{32'd0, r} : {32'd0, r}) & mask;
        c0   = sub ? ~cin : cin;
        full = ({32'd0, l} & mask) + b + {63'd0, c0};
        s    = full[31:0] & mask[31:0];
        co   = full[w];
        ov   = (l[w-1] == b[w-1]) && (s[w-1] != l[w-1]);
        return {ov, co, s};
    endfunction

    function automatic logic [31:0] rnd32();
        case ($urandom_range(0, 7))
            0:       return 32'hFFFF_FFFF;
            1:       return 32'h8000_0000;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h0000_0000;
            default: return $urandom();
        endcase
    endfunction

    // Scoreboard: push on input transfer, pop and compare on output transfer.
    always @(negedge clk) begin
        if (reset) begin
            if (bus8.io_in_valid && bus8.io_in_ready) q8.push_back(exp8_next);
            if (bus8.io_out_valid && bus8.io_out_ready) begin
                if (q8.size() == 0) check_val("sb8_underflow", 64'(q8.size()), 64'd1);
                else begin
                    e8 = q8.pop_front();
                    check_val("res8", 64'({bus8.io_out_ovf, bus8.io_out_cout, 24'd0, bus8.io_out_sum}), 64'(e8));
                end
            end
            if (bus32.io_in_valid && bus32.io_in_ready)
                q32.push_back(model(32, bus32.io_in_lhs, bus32.io_in_rhs, bus32.io_in_cin, bus32.io_in_sub));
            if (bus32.io_out_valid && bus32.io_out_ready) begin
                if (q32.size() == 0) check_val("sb32_underflow", 64'(q32.size()), 64'd1);
                else begin
                    e32 = q32.pop_front();
                    check_val("res32", 64'({bus32.io_out_ovf, bus32.io_out_cout, bus32.io_out_sum}), 64'(e32));
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rnd8_en) begin
            #1;
            bus8.io_out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send8(input logic [7:0] l, input logic [7:0] r, input logic cin, input logic sub,
                         input logic [33:0] e);
        logic acc;
        acc = 1'b0;
        bus8.io_in_lhs   = l;
        bus8.io_in_rhs   = r;
        bus8.io_in_cin   = cin;
        bus8.io_in_sub   = sub;
        exp8_next        = e;
        bus8.io_in_valid = 1'b1;
        for (int t = 0; t < 100 && !acc; t++) begin
            @(negedge clk);
            acc = bus8.io_in_ready;
            @(posedge clk);
            #1;
        end
        bus8.io_in_valid = 1'b0;
        if (!acc) check_val("send8_timeout", 64'(acc), 64'd1);
    endtask

    task automatic drain(input bit is32);
        bus8.io_out_ready  = 1'b1;
        bus32.io_out_ready = 1'b1;
        for (int t = 0; t < 200 && (q8.size() != 0 || q32.size() != 0); t++) begin
            @(posedge clk);
            #1;
        end
        if (is32) check_val("drain32", 64'(q32.size()), 64'd0);
        else      check_val("drain8", 64'(q8.size()), 64'd0);
    endtask

    task automatic check_idle(input string tag);
        check_val({tag, "_v8"},   64'({bus8.io_out_valid, bus8.io_in_ready}), 64'b01);
        check_val({tag, "_o8"},   64'({bus8.io_out_ovf, bus8.io_out_cout, bus8.io_out_sum}), 64'd0);
        check_val({tag, "_v32"},  64'({bus32.io_out_valid, bus32.io_in_ready}), 64'b01);
        check_val({tag, "_o32"},  64'({bus32.io_out_ovf, bus32.io_out_cout, bus32.io_out_sum}), 64'd0);
    endtask

    initial begin
        int          idx;
        int          sent32;
        int          seen;
        logic        acc;
        logic [7:0]  l8;
        logic [7:0]  r8;
        logic        ci;
        logic        sb;

        reset = 1'b1;
        bus8.io_in_valid  = 1'b0; bus8.io_in_lhs  = 8'd0;  bus8.io_in_rhs  = 8'd0;
        bus8.io_in_cin    = 1'b0; bus8.io_in_sub  = 1'b0;  bus8.io_out_ready  = 1'b1;
        bus32.io_in_valid = 1'b0; bus32.io_in_lhs = 32'd0; bus32.io_in_rhs = 32'd0;
        bus32.io_in_cin   = 1'b0; bus32.io_in_sub = 1'b0;  bus32.io_out_ready = 1'b1;
        exp8_next = 34'd0;
        #2 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // 0xFF+0x01 with exact two-cycle latency on an empty pipe
        bus8.io_in_lhs = 8'hFF; bus8.io_in_rhs = 8'h01; bus8.io_in_cin = 1'b0; bus8.io_in_sub = 1'b0;
        exp8_next = {1'b0, 1'b1, 32'h0000_0000};
        bus8.io_in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus8.io_in_valid = 1'b0;
        check_val("t1_accept", 64'(q8.size()), 64'd1);
        check_val("lat_early", 64'(bus8.io_out_valid), 64'd0);
        @(posedge clk);
        #1;
        check_val("lat_exact", 64'(bus8.io_out_valid), 64'd1);
        @(posedge clk);
        #1;

        send8(8'h7F, 8'h01, 1'b0, 1'b0, {1'b1, 1'b0, 32'h0000_0080});
        send8(8'h0F, 8'h01, 1'b1, 1'b0, {1'b0, 1'b0, 32'h0000_0011});
        send8(8'h05, 8'h07, 1'b0, 1'b1, {1'b0, 1'b0, 32'h0000_00FE});
        send8(8'h80, 8'h01, 1'b0, 1'b1, {1'b1, 1'b1, 32'h0000_007F});
        drain(1'b0);

        // Back-to-back stream with output stalled in cycles 3..6
        idx = 0;
        for (int c = 0; c < 30; c++) begin
            bus8.io_out_ready = !(c >= 3 && c <= 6);
            if (idx < 8) begin
                bus8.io_in_valid = 1'b1;
                bus8.io_in_lhs   = 8'(idx);
                bus8.io_in_rhs   = 8'(idx);
                bus8.io_in_cin   = 1'b0;
                bus8.io_in_sub   = 1'b0;
                exp8_next        = {2'b00, 32'(2 * idx)};
            end else begin
                bus8.io_in_valid = 1'b0;
            end
            @(negedge clk);
            acc = bus8.io_in_valid && bus8.io_in_ready;
            if (c == 5) begin
                check_val("full_in_ready", 64'(bus8.io_in_ready), 64'd0);
                check_val("stall_valid", 64'(bus8.io_out_valid), 64'd1);
                check_val("stall_depth", 64'(q8.size()), 64'd2);
                if (q8.size() != 0) check_val("stall_hold", 64'(bus8.io_out_sum), 64'(q8[0][7:0]));
            end
            @(posedge clk);
            #1;
            if (acc) idx++;
        end
        bus8.io_in_valid = 1'b0;
        check_val("stream_sent", 64'(idx), 64'd8);
        drain(1'b0);

        // Randomized 8-bit traffic against the model with random output stalls
        rnd8_en = 1'b1;
        for (int i = 0; i < 200; i++) begin
            l8 = 8'($urandom()); r8 = 8'($urandom());
            ci = 1'($urandom_range(0, 1)); sb = 1'($urandom_range(0, 1));
            send8(l8, r8, ci, sb, model(8, {24'd0, l8}, {24'd0, r8}, ci, sb));
        end
        rnd8_en = 1'b0;
        @(posedge clk);
        #1;
        drain(1'b0);

        // Fill the pipe, then reset mid-cycle: in-flight beats must vanish
        bus8.io_out_ready = 1'b0;
        send8(8'h11, 8'h22, 1'b0, 1'b0, {2'b00, 32'h0000_0033});
        send8(8'h33, 8'h44, 1'b0, 1'b0, {2'b00, 32'h0000_0077});
        check_val("fill_full", 64'({bus8.io_out_valid, bus8.io_in_ready}), 64'b10);
        #2 reset = 1'b0;
        #1;
        check_idle("midreset");
        q8.delete();
        q32.delete();
        @(negedge clk);
        reset = 1'b1;
        bus8.io_out_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            if (bus8.io_out_valid) seen++;
        end
        check_val("no_stale", 64'(seen), 64'd0);

        // 10k random beats through the 32-bit/4-stage unit
        sent32 = 0;
        for (int c = 0; c < 60000 && sent32 < 10000; c++) begin
            bus32.io_in_valid  = ($urandom_range(0, 3) != 0);
            bus32.io_in_lhs    = rnd32();
            bus32.io_in_rhs    = rnd32();
            bus32.io_in_cin    = 1'($urandom_range(0, 1));
            bus32.io_in_sub    = 1'($urandom_range(0, 1));
            bus32.io_out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (bus32.io_in_valid && bus32.io_in_ready) sent32++;
            @(posedge clk);
            #1;
        end
        bus32.io_in_valid = 1'b0;
        check_val("rand32_sent", 64'(sent32), 64'd10000);
        drain(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
